// File: rtl/pkg_dtypes.sv
// Shared front-end datatypes: issue-queue entry payload, EU count and dispatch FSM states.
package pkg_dtypes;

    localparam int unsigned LOG2_NUM_EXEC_UNITS = 2;
    localparam int unsigned NUM_EXEC_UNITS      = 1 << LOG2_NUM_EXEC_UNITS;
    localparam int unsigned CREDIT_W            = 8;

    typedef struct packed {
        logic [7:0] opcode;
        logic [5:0] dst;
        logic [5:0] src1;
        logic [5:0] src2;
        logic [7:0] imm;
    } type_iqueue_entry;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        HALT     = 2'd2
    } type_dispatch_ctrl_state;

endpackage

// File: rtl/eu_dispatch_alloc.sv
// Combinational lane-ordered credit allocator: grants pending lanes to EUs round-robin,
// stopping at the first pending lane that finds no EU with credit left.
module eu_dispatch_alloc
    import pkg_dtypes::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]                          pending,
    input  logic [NUM_EXEC_UNITS-1:0][CREDIT_W-1:0]       credit,
    input  logic [LOG2_NUM_EXEC_UNITS-1:0]                rr_ptr,
    output logic [NUM_LANES-1:0]                          grant,
    output logic [NUM_LANES-1:0][LOG2_NUM_EXEC_UNITS-1:0] euidx,
    output logic [NUM_EXEC_UNITS-1:0][CNT_W-1:0]          eu_count,
    output logic [LOG2_NUM_EXEC_UNITS-1:0]                rr_next
);

    logic [NUM_EXEC_UNITS-1:0][CREDIT_W-1:0] avail;
    logic [LOG2_NUM_EXEC_UNITS-1:0]          start;
    logic [LOG2_NUM_EXEC_UNITS-1:0]          cand;
    logic [LOG2_NUM_EXEC_UNITS-1:0]          pick;
    logic                                    found;
    logic                                    blocked;

    // avail tracks credit left after earlier lanes of this same cycle
    always_comb begin
        grant    = '0;
        euidx    = '0;
        eu_count = '0;
        rr_next  = rr_ptr;
        avail    = credit;
        start    = rr_ptr;
        cand     = '0;
        pick     = '0;
        found    = 1'b0;
        blocked  = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            found = 1'b0;
            pick  = '0;
            for (int unsigned k = 0; k < NUM_EXEC_UNITS; k++) begin
                cand = start + LOG2_NUM_EXEC_UNITS'(k);
                if (!found && (avail[cand] != '0)) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
            if (pending[i] && !blocked) begin
                if (found) begin
                    grant[i]        = 1'b1;
                    euidx[i]        = pick;
                    avail[pick]     = avail[pick] - CREDIT_W'(1);
                    eu_count[pick]  = eu_count[pick] + CNT_W'(1);
                    start           = pick + LOG2_NUM_EXEC_UNITS'(1);
                    rr_next         = start;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eu_dispatch_ctrl.sv
// Dispatch scheduler: holds one rename batch and releases it lane-in-order to EU queues under credit control.
// Optional performance counters are built when EU_DISPATCH_PERF_CTR_EN is defined.
module eu_dispatch_ctrl
    import pkg_dtypes::*;
#(
    parameter int unsigned NUM_PARALLEL_INSTR_DISPATCHES = 4,
    parameter int unsigned EU_CREDITS                    = 16
) (
    input  logic                                                               clk,
    input  logic                                                               reset_n,
    input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]               batch_instr_i,
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                           batch_lane_valid_i,
    input  logic                                                               batch_valid_i,
    output logic                                                               batch_ready_o,
    input  logic                                                               flush_i,
    input  logic [NUM_EXEC_UNITS-1:0]                                          eu_issue_i,
    input  logic [NUM_EXEC_UNITS-1:0]                                          eu_full_i,
    output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]               dispatched_instr_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                           dispatched_instr_valid_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0]  dispatched_instr_alloc_euidx_o,
`ifdef EU_DISPATCH_PERF_CTR_EN
    output logic                                                               overflow_err_o,
    output logic [31:0]                                                        perf_stall_cycles_o,
    output logic [31:0]                                                        perf_dispatched_o
`else
    output logic                                                               overflow_err_o
`endif
);

    localparam int unsigned N     = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(EU_CREDITS);

    type_dispatch_ctrl_state state, state_next;
    logic [N-1:0]                            pending, pending_next;
    type_iqueue_entry [N-1:0]                batch, batch_next;
    logic [LOG2_NUM_EXEC_UNITS-1:0]          rr_ptr, rr_ptr_next, rr_alloc;
    logic [NUM_EXEC_UNITS-1:0][CREDIT_W-1:0] credit, credit_next;
    logic [N-1:0]                            grant;
    logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0]   alloc_euidx;
    logic [NUM_EXEC_UNITS-1:0][CNT_W-1:0]    eu_count;
    logic                                    dispatch_en;
    logic                                    all_grant;
    logic                                    accept;
    logic                                    err_set;

    eu_dispatch_alloc #(
        .NUM_LANES (N),
        .CNT_W     (CNT_W)
    ) u_alloc (
        .pending  (pending),
        .credit   (credit),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .euidx    (alloc_euidx),
        .eu_count (eu_count),
        .rr_next  (rr_alloc)
    );

    // flush suppresses this cycle's grants so credits only see eu_issue_i
    assign dispatch_en = (state == DISPATCH) && !flush_i;
    assign all_grant   = (grant == pending);
    assign accept      = batch_valid_i && batch_ready_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pending        <= '0;
            batch          <= '0;
            rr_ptr         <= '0;
            credit         <= {NUM_EXEC_UNITS{CREDIT_INIT}};
            overflow_err_o <= 1'b0;
        end else begin
            state          <= state_next;
            pending        <= pending_next;
            batch          <= batch_next;
            rr_ptr         <= rr_ptr_next;
            credit         <= credit_next;
            overflow_err_o <= overflow_err_o | err_set;
        end
    end

    // Next state plus credit/pending bookkeeping; HALT freezes everything until reset
    always_comb begin
        state_next   = state;
        pending_next = pending;
        batch_next   = batch;
        rr_ptr_next  = rr_ptr;
        credit_next  = credit;
        err_set      = 1'b0;
        if (state != HALT) begin
            for (int unsigned e = 0; e < NUM_EXEC_UNITS; e++) begin
                if (eu_issue_i[e] && (credit[e] == CREDIT_INIT) && !(dispatch_en && (eu_count[e] != '0))) begin
                    err_set = 1'b1;
                end else begin
                    credit_next[e] = credit[e]
                                   - (dispatch_en ? CREDIT_W'(eu_count[e]) : CREDIT_W'(0))
                                   + CREDIT_W'(eu_issue_i[e]);
                end
                if (eu_full_i[e] && dispatch_en && (eu_count[e] != '0)) begin
                    err_set = 1'b1;
                end
            end
            if (dispatch_en && (grant != '0)) begin
                rr_ptr_next = rr_alloc;
            end
            if (err_set) begin
                state_next = HALT;
            end else if (flush_i) begin
                pending_next = '0;
                state_next   = IDLE;
            end else begin
                if (state == DISPATCH) begin
                    pending_next = pending & ~grant;
                end
                if (accept) begin
                    batch_next   = batch_instr_i;
                    pending_next = batch_lane_valid_i;
                end
                state_next = (pending_next != '0) ? DISPATCH : IDLE;
            end
        end
    end

    // Bus and handshake decode from registered state
    always_comb begin
        batch_ready_o                  = 1'b0;
        dispatched_instr_o             = '0;
        dispatched_instr_valid_o       = '0;
        dispatched_instr_alloc_euidx_o = '0;
        case (state)
            IDLE:     batch_ready_o = !flush_i;
            DISPATCH: batch_ready_o = !flush_i && all_grant;
            default:  batch_ready_o = 1'b0;
        endcase
        for (int unsigned l = 0; l < N; l++) begin
            if (dispatch_en && grant[l]) begin
                dispatched_instr_valid_o[l]       = 1'b1;
                dispatched_instr_o[l]             = batch[l];
                dispatched_instr_alloc_euidx_o[l] = alloc_euidx[l];
            end
        end
    end

`ifdef EU_DISPATCH_PERF_CTR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles_o <= '0;
            perf_dispatched_o   <= '0;
        end else begin
            if ((state == DISPATCH) && (pending != '0) && (dispatched_instr_valid_o == '0)) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            end
            perf_dispatched_o <= perf_dispatched_o + 32'($countones(dispatched_instr_valid_o));
        end
    end
`endif

endmodule

// File: doc/eu_dispatch_ctrl.md
Name: eu_dispatch_ctrl

Overview:
- Front-end dispatch scheduler. Holds one rename batch of up to NUM_PARALLEL_INSTR_DISPATCHES instructions and allocates each valid lane to an exec unit (EU) instruction queue.
- Drives the shared dispatch bus (instr, valid, alloc euidx per lane) that every EU queue snoops.
- Tracks per-EU credits so it never sends more entries to an EU than it can hold, and releases the batch lane-in-order over one or more cycles.

Parameters:
- NUM_PARALLEL_INSTR_DISPATCHES, 4, dispatch bus lanes.
- LOG2_NUM_EXEC_UNITS, 2, log2 of EU count; NUM_EU = 2**LOG2_NUM_EXEC_UNITS.
- EU_CREDITS, 16, guaranteed free entries per EU queue at reset; range 1..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- batch_instr_i  in  type_iqueue_entry x N  incoming rename batch.
- batch_lane_valid_i  in  N  per-lane valid.
- batch_valid_i  in  1  batch offered.
- batch_ready_o  out  1  batch accepted when batch_valid_i & batch_ready_o.
- flush_i  in  1  discard held batch.
- eu_issue_i  in  NUM_EU  one-cycle pulse: EU e removed one entry from its queue (returns 1 credit).
- eu_full_i  in  NUM_EU  EU queue-full flags; safety check only.
- dispatched_instr_o  out  type_iqueue_entry x N  dispatch bus payload.
- dispatched_instr_valid_o  out  N  per-lane valid.
- dispatched_instr_alloc_euidx_o  out  LOG2_NUM_EXEC_UNITS x N  target EU per lane.
- overflow_err_o  out  1  sticky protocol/credit error.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pending mask=0; held batch=0; rr_ptr=0.
  - all credits=EU_CREDITS; overflow_err_o=0.
  - outputs: batch_ready_o=1, all dispatch valids=0, instr/euidx=0.
- FSM IDLE / DISPATCH / HALT:
  - IDLE: batch_ready_o=1. On accept, latch batch; pending=batch_lane_valid_i; go to DISPATCH if pending!=0, else stay.
  - DISPATCH: each cycle, allocate pending lanes in ascending lane order.
  - HALT: entered on overflow error. Dispatch valids=0, batch_ready_o=0 until reset.
- Allocation, per cycle:
  - Search for the first lane starts at rr_ptr. Each later lane starts at (previous lane's EU + 1) mod NUM_EU.
  - A lane takes the first EU with remaining credit > 0, counting lanes already allocated this cycle.
  - Allocation stops at the first pending lane with no EU available; later lanes wait (strict lane order).
  - Allocated lanes: valid=1, payload from held batch, euidx=chosen EU, bus position = original lane index.
  - Non-allocated lanes: valid=0, payload=0.
  - Allocated lanes clear from pending. rr_ptr <= last allocated EU + 1 (unchanged if none allocated).
- Dispatch outputs are combinational from registered state only. No input-to-output path except through credits and pending.
- Latency: batch accepted at cycle T, first lanes on bus at T+1.
- Back-to-back batches: in DISPATCH, batch_ready_o=1 when every pending lane allocates this cycle. A new batch accepted that cycle loads at the same edge and stays in DISPATCH, giving one batch per cycle when credits allow.
- Credits:
  - credit_next[e] = credit[e] - allocated_count[e] + eu_issue_i[e].
  - Issue and allocation in the same cycle both apply.
  - eu_issue_i[e] when credit[e]==EU_CREDITS with nothing allocated to e: credit saturates, overflow_err_o set, go to HALT.
- Safety check: eu_full_i[e] high in a cycle where a lane is dispatched to e sets overflow_err_o and goes to HALT.
- flush_i: pending cleared, state -> IDLE next cycle, this cycle's dispatch suppressed, credits unaffected except eu_issue_i. Flush has priority over batch accept (batch_ready_o=0 while flush_i=1).
- Lanes with batch_lane_valid_i=0 are never dispatched.

Optional Feature:
- Macro EU_DISPATCH_PERF_CTR_EN.
- When defined, adds outputs perf_stall_cycles_o (32b) and perf_dispatched_o (32b), both reset to 0 and wrapping at 2^32:
  - perf_stall_cycles_o counts DISPATCH cycles with pending!=0 and zero lanes allocated.
  - perf_dispatched_o counts allocated lanes.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Reuse pkg_dtypes: type_iqueue_entry, LOG2_NUM_EXEC_UNITS.
- Add to pkg_dtypes: enum type_dispatch_ctrl_state {IDLE, DISPATCH, HALT}.
- One sub-module: eu_dispatch_alloc. Purely combinational lane-ordered credit allocator; inputs are pending mask, credits and rr_ptr; outputs are per-lane grant/euidx, per-EU counts and the next rr_ptr. The FSM, credits and held batch stay in the top module.

Test Plan:
- Reset, 4 valid lanes, all credits 16, NUM_EU=4 -> T+1 lanes 0..3 to EUs 0,1,2,3; batch_ready_o=1 that cycle; rr_ptr=0.
- EU_CREDITS=1, NUM_EU=4, two 4-lane batches back-to-back, no issue pulses -> batch 1 dispatched, batch 2 held with all valids 0; one eu_issue_i[2] pulse -> next cycle lane 0 dispatched to EU2 only.
- Lane valid mask 4'b1010 -> only lanes 1 and 3 valid on bus at original positions, to EUs 0 and 1.
- flush_i mid-batch with 2 lanes pending -> bus valids 0 from that cycle, IDLE next cycle, credits unchanged.
- eu_full_i[0]=1 while a lane targets EU0 -> overflow_err_o=1 next cycle, HALT, batch_ready_o=0 until reset_n pulse.
- eu_issue_i[1] at full credit -> overflow_err_o=1; async reset_n low mid-DISPATCH -> all outputs reset values immediately.
